// File: rtl/raw_array.sv
// raw_array: NUM_ENTRIES-word read-add/sub-write stateful atom behind a 2-stage valid-qualified pipeline.
// Optional saturating arithmetic (with o__sat output) is enabled by defining RAW_ARRAY_SAT_EN.
module raw_array #(
  parameter  int COUNT_WIDTH = 32,
  parameter  int NUM_ENTRIES = 16,
  localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i__valid,
  input  logic [IDX_WIDTH-1:0]   i__idx,
  input  logic [COUNT_WIDTH-1:0] i__constant,
  input  logic [COUNT_WIDTH-1:0] i__pkt_1,
  input  logic                   i__sel1,
  input  logic                   i__sel2,
  input  logic                   i__sub,
  input  logic                   i__clear,
  output logic                   o__valid,
  output logic [IDX_WIDTH-1:0]   o__idx,
  output logic [COUNT_WIDTH-1:0] o__read,
`ifdef RAW_ARRAY_SAT_EN
  output logic                   o__sat,
`endif
  output logic [COUNT_WIDTH-1:0] o__write
);

  // Handshake: valid-only, no backpressure. A packet is accepted on every edge
  // where i__valid is high; o__valid marks the one cycle its result is presented.

  logic [COUNT_WIDTH-1:0] entries [NUM_ENTRIES];

  // Stage 1 registers
  logic                   s1_valid;
  logic [IDX_WIDTH-1:0]   s1_idx;
  logic [COUNT_WIDTH-1:0] s1_constant;
  logic [COUNT_WIDTH-1:0] s1_pkt_1;
  logic                   s1_sel1;
  logic                   s1_sel2;
  logic                   s1_sub;

  // Stage 2 registers
  logic                   s2_valid;
  logic [IDX_WIDTH-1:0]   s2_idx;
  logic [COUNT_WIDTH-1:0] s2_constant;
  logic [COUNT_WIDTH-1:0] s2_pkt_1;
  logic                   s2_sel1;
  logic                   s2_sel2;
  logic                   s2_sub;
  logic [COUNT_WIDTH-1:0] s2_rd;

  logic [COUNT_WIDTH-1:0] a_op;
  logic [COUNT_WIDTH-1:0] b_op;
  logic [COUNT_WIDTH-1:0] wr_data;
  logic                   sat_hit;
  logic                   fwd;
  logic [COUNT_WIDTH-1:0] rd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_constant <= '0;
      s1_pkt_1    <= '0;
      s1_sel1     <= 1'b0;
      s1_sel2     <= 1'b0;
      s1_sub      <= 1'b0;
    end else begin
      s1_valid    <= i__valid;
      s1_idx      <= i__idx;
      s1_constant <= i__constant;
      s1_pkt_1    <= i__pkt_1;
      s1_sel1     <= i__sel1;
      s1_sel2     <= i__sel2;
      s1_sub      <= i__sub;
    end
  end

  // The S2 packet writes its entry on the same edge S1 reads it, so a matching
  // index must take the in-flight result; a clear on that edge overrides both.
  always_comb begin
    fwd     = s1_valid && s2_valid && (s1_idx == s2_idx);
    rd_next = entries[s1_idx];
    if (i__clear) begin
      rd_next = '0;
    end else if (fwd) begin
      rd_next = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_idx      <= '0;
      s2_constant <= '0;
      s2_pkt_1    <= '0;
      s2_sel1     <= 1'b0;
      s2_sel2     <= 1'b0;
      s2_sub      <= 1'b0;
      s2_rd       <= '0;
    end else begin
      s2_valid    <= s1_valid;
      s2_idx      <= s1_idx;
      s2_constant <= s1_constant;
      s2_pkt_1    <= s1_pkt_1;
      s2_sel1     <= s1_sel1;
      s2_sel2     <= s1_sel2;
      s2_sub      <= s1_sub;
      s2_rd       <= rd_next;
    end
  end

  always_comb begin
    a_op = s2_sel1 ? s2_pkt_1 : s2_constant;
    b_op = s2_sel2 ? '0 : s2_rd;
  end

`ifdef RAW_ARRAY_SAT_EN
  logic [COUNT_WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = {1'b0, b_op} + {1'b0, a_op};
    sat_hit = 1'b0;
    if (s2_sub) begin
      if (a_op > b_op) begin
        wr_data = '0;
        sat_hit = 1'b1;
      end else begin
        wr_data = b_op - a_op;
      end
    end else begin
      if (sum_ext[COUNT_WIDTH]) begin
        wr_data = '1;
        sat_hit = 1'b1;
      end else begin
        wr_data = sum_ext[COUNT_WIDTH-1:0];
      end
    end
  end

  assign o__sat = s2_valid && sat_hit;
`else
  always_comb begin
    sat_hit = 1'b0;
    wr_data = s2_sub ? (b_op - a_op) : (b_op + a_op);
  end
`endif

  // Outputs are held at zero outside valid cycles.
  always_comb begin
    o__valid = s2_valid;
    o__idx   = s2_valid ? s2_idx  : '0;
    o__read  = s2_valid ? s2_rd   : '0;
    o__write = s2_valid ? wr_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (i__clear) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (s2_valid) begin
      entries[s2_idx] <= wr_data;
    end
  end

endmodule

// File: doc/raw_array.md
Name: raw_array

Overview:
- Parametrised successor of the single-register read-add-write stateful atom.
- Holds NUM_ENTRIES state words, selected per packet by an index field, behind a 2-stage pipeline with valid qualification.
- Same-index back-to-back hazards are resolved by forwarding; adds a subtract mode and a synchronous bulk clear.
- Sits in the stateful-atom slot of a pipeline stage; one packet per cycle, no stalls.

Parameters:
COUNT_WIDTH, 32, width of state words, operands and results
NUM_ENTRIES, 16, number of state words; must be a power of two, at least 2
IDX_WIDTH, $clog2(NUM_ENTRIES), width of the index field (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i__valid  input  1  packet present this cycle
i__idx  input  IDX_WIDTH  state entry selected by the packet
i__constant  input  COUNT_WIDTH  immediate operand
i__pkt_1  input  COUNT_WIDTH  packet-field operand
i__sel1  input  1  operand A select: 0 = constant, 1 = pkt_1
i__sel2  input  1  operand B select: 0 = state, 1 = zero
i__sub  input  1  0 = B+A, 1 = B-A
i__clear  input  1  synchronous clear of all entries
o__valid  output  1  result valid
o__idx  output  IDX_WIDTH  index of the result
o__read  output  COUNT_WIDTH  pre-update state value of the entry
o__write  output  COUNT_WIDTH  new state value written to the entry

Behaviour:
- Reset (rst_n low, asynchronous): all entries = 0; S1/S2 valids = 0; all S1/S2 data registers = 0. Outputs are 0 while o__valid = 0.
- S1: at the clock edge, register i__valid, idx, constant, pkt_1, sel1, sel2 and sub.
- S2: at the next edge, register the S1 controls plus the state read at the S1 index.
- Forwarding: when S1 is valid, S2 is valid, and their indices match, S2 captures S2's o__write instead of the array value.
- Compute in S2 (combinational):
  - A = sel1 ? pkt_1 : constant.
  - B = sel2 ? 0 : rd.
  - o__write = sub ? B-A : B+A, truncated modulo 2^COUNT_WIDTH.
  - o__read = rd.
  - o__valid = S2 valid.
  - o__idx = S2 idx.
- Write: at the edge ending S2, entry[o__idx] <= o__write when o__valid = 1.
- Latency: a packet sampled at edge N produces outputs in the cycle after edge N+1. The entry is updated at edge N+2. Throughput is 1 packet per cycle.
- Invalid cycles (i__valid = 0) are bubbles: no write, and no forwarding from a bubble.
- i__clear high at edge E:
  - All entries become 0 at E. Clear wins over any S2 write at E.
  - A valid S1 packet advancing at E captures rd = 0, with no forwarding.
  - S1 and S2 valids are otherwise unaffected.
- Same index at both pipeline positions continuously: each packet sees the previous packet's result. The chain is correct for any run length.
- Wrap-around: the add wraps modulo 2^COUNT_WIDTH. The subtract wraps below 0 (two's complement).
- Reset mid-operation: all in-flight packets are discarded, with no partial writes.

Optional Feature:
- Macro: RAW_ARRAY_SAT_EN.
- Defined:
  - Add saturates at 2^COUNT_WIDTH-1.
  - Subtract saturates at 0 when A > B.
  - Extra output o__sat (1 bit, 0 at reset) is high with o__valid when clamping occurred.
- Undefined: modulo arithmetic as above; the o__sat port does not exist.

Test Plan:
- Reset, then idx=3, sel1=0, constant=5, sel2=0, sub=0 for three consecutive packets -> o__read 0,5,10; o__write 5,10,15; entry 3 = 15.
- Alternate idx 1 and 2 with pkt_1=7, sel1=1, four packets -> each index accumulates independently: idx1 writes 7,14; idx2 writes 7,14.
- idx=0 preloaded to 10; packet sub=1, constant=3, then sub=1, constant=20 -> o__write 7, then 2^32-13 (0 with o__sat=1 under RAW_ARRAY_SAT_EN).
- Entry at 0xFFFFFFFE, add constant 5 -> o__write 3 (0xFFFFFFFF with o__sat=1 under RAW_ARRAY_SAT_EN).
- i__clear pulsed while a same-index packet sits in S2 and another in S1 -> entry reads 0 afterwards; the S1 packet's o__read = 0; the S2 write is lost.
- sel2=1 with pkt_1=9 on a nonzero entry -> o__write 9 (overwrite). Assert rst_n low mid-stream -> o__valid drops immediately; all entries read 0 after release.
